// File: rtl/simple_fixed_point_signed_long_multiplication.sv
// ---------------------------------------------------------------------------
// simple_fixed_point_signed_long_multiplication
//
// Iterative signed fixed-point shift-and-add multiplier. Two signed
// Q(WIDTH-FRAC).FRAC operands are reduced to magnitudes and multiplied over
// WIDTH add/shift steps. One more cycle rescales the product by FRAC, checks
// for overflow and restores the sign. The result is a WIDTH-bit value in the
// same Q format as the operands.
//
// Optional build macro: SIGNED_MUL_SATURATION_EN
//   defined   : an overflowing result clamps to the most negative or most
//               positive representable value.
//   undefined : an overflowing result wraps to the low WIDTH bits of the
//               signed product.
//   o_overflow is reported in both builds. Timing is identical in both.
//
// Ports
//   i_clk       in   1      clock, rising edge
//   i_reset     in   1      synchronous reset, active high
//   i_valid     in   1      operands valid (accepted only while o_ready=1)
//   o_ready     out  1      idle, operands can be accepted
//   i_data_a    in   WIDTH  signed multiplicand
//   i_data_b    in   WIDTH  signed multiplier
//   o_valid     out  1      single-cycle result strobe
//   o_data      out  WIDTH  signed product; holds until the next result
//   o_overflow  out  1      product not representable, qualified by o_valid
//
// Timing
//   Operands accepted at edge N. The accumulate steps happen at edges N+1
//   to N+WIDTH. The result is registered at edge N+WIDTH+1, and o_valid is
//   high for the cycle that follows that edge.
// ---------------------------------------------------------------------------
module simple_fixed_point_signed_long_multiplication #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  // The counter reaches WIDTH once every multiplier bit has been consumed.
  localparam logic [CW-1:0]      CNT_DONE = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  // 2^(WIDTH-1) and 2^(WIDTH-1)-1, widened to the accumulator width.
  localparam logic [2*WIDTH-1:0] HALF_2W    = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] POS_MAX_2W = HALF_2W - {{(2*WIDTH-1){1'b0}}, 1'b1};

`ifdef SIGNED_MUL_SATURATION_EN
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] ma;          // shifted multiplicand magnitude
  logic [WIDTH-1:0]   mb;          // remaining multiplier magnitude bits
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               sign;

  logic [2*WIDTH-1:0] mag;
  logic [WIDTH-1:0]   mag_low;
  logic [WIDTH-1:0]   wrap_val;
  logic [WIDTH-1:0]   result;
  logic               ovf;

  // Two's-complement magnitude. The most negative input maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + ONE_W;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Next-state decode for the IDLE -> CALC -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (cnt == CNT_DONE) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register. The handshake outputs are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      state   <= state_next;
      o_ready <= (state_next == IDLE);
      o_valid <= (state_next == DONE);
    end
  end

  // Rescale, overflow check and sign restore for the finished accumulator.
  always_comb begin
    mag      = acc >> FRAC;
    mag_low  = mag[WIDTH-1:0];
    ovf      = 1'b0;
    wrap_val = mag_low;
    result   = mag_low;
    // A negative result may reach 2^(WIDTH-1); a positive one only 2^(WIDTH-1)-1.
    if (sign) begin
      ovf      = (mag > HALF_2W);
      wrap_val = ~mag_low + ONE_W;   // -0 yields +0
    end else begin
      ovf      = (mag > POS_MAX_2W);
      wrap_val = mag_low;
    end
`ifdef SIGNED_MUL_SATURATION_EN
    if (ovf) begin
      result = sign ? SAT_NEG : SAT_POS;
    end else begin
      result = wrap_val;
    end
`else
    result = wrap_val;
`endif
  end

  // Datapath: operand capture, shift-and-add steps and result register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ma         <= {(2*WIDTH){1'b0}};
      mb         <= {WIDTH{1'b0}};
      acc        <= {(2*WIDTH){1'b0}};
      cnt        <= {CW{1'b0}};
      sign       <= 1'b0;
      o_data     <= {WIDTH{1'b0}};
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            ma   <= {{WIDTH{1'b0}}, abs_val(i_data_a)};
            mb   <= abs_val(i_data_b);
            sign <= i_data_a[WIDTH-1] ^ i_data_b[WIDTH-1];
            acc  <= {(2*WIDTH){1'b0}};
            cnt  <= {CW{1'b0}};
          end
        end
        CALC: begin
          if (cnt != CNT_DONE) begin
            if (mb[0]) begin
              acc <= acc + ma;
            end
            ma  <= {ma[2*WIDTH-2:0], 1'b0};
            mb  <= {1'b0, mb[WIDTH-1:1]};
            cnt <= cnt + CNT_ONE;
          end else begin
            o_data     <= result;
            o_overflow <= ovf;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
